// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use/branch interlocks, multi-cycle multiplier FSM, D-cache miss freeze.
// Optional macro HAZARD_STATS_EN adds a saturating stallcnt output counting stallF cycles.
module hazard_unit_mc #(
    parameter int unsigned REGW       = 5,
    parameter int unsigned MUL_LAT    = 32,
    parameter logic [3:0]  LOAD_WBSRC = 4'b1111
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      branchD,
    input  logic [3:0]      wbsrcE,
    input  logic [3:0]      wbsrcM,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memopM,
    input  logic            hitM,
    input  logic            multstartE,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] writeregE,
    input  logic [REGW-1:0] writeregM,
    input  logic [REGW-1:0] writeregW,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            flushE,
    output logic            flushM,
    output logic            flushW,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            mulbusy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]     stallcnt
`endif
);

    localparam int unsigned CNTW = $clog2(MUL_LAT);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    logic [0:0]      state;
    logic [0:0]      stateNext;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cntNext;
    logic            mulStall;
    logic            lu;
    logic            br;
    logic            ms;
    logic            srcMatchE;
    logic            srcMatchM;

    // Hazard detection terms; register 0 is never a real dependency.
    always_comb begin
        srcMatchE = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
        srcMatchM = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
        lu        = (wbsrcE == LOAD_WBSRC) && regwriteE && srcMatchE;
        br        = (branchD != 2'b00) &&
                    ((regwriteE && srcMatchE) || ((wbsrcM == LOAD_WBSRC) && srcMatchM));
        ms        = memopM && !hitM;
    end

    // Multiplier FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Stall is raised on the start cycle plus MUL_LAT-1 busy cycles; the count runs even under a miss.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mulStall  = 1'b0;
        case (state)
            IDLE: begin
                if (multstartE) begin
                    mulStall  = 1'b1;
                    stateNext = MUL_BUSY;
                    cntNext   = CNTW'(MUL_LAT - 1);
                end
            end
            MUL_BUSY: begin
                if (cnt != '0) begin
                    mulStall = 1'b1;
                    cntNext  = cnt - CNTW'(1);
                end else if (!ms) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Output combination; everything is forced low while reset is asserted.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        mulbusy   = 1'b0;
        if (reset_n) begin
            stallF  = lu || br || ms || mulStall;
            stallD  = lu || br || ms || mulStall;
            stallE  = ms || mulStall;
            stallM  = ms;
            flushE  = (lu || br) && !stallE;
            flushM  = mulStall && !stallM;
            flushW  = ms;
            mulbusy = (state == MUL_BUSY);

            forwardAD = (rsD != '0) && regwriteM && (rsD == writeregM);
            forwardBD = (rtD != '0) && regwriteM && (rtD == writeregM);

            if ((rsE != '0) && regwriteM && (rsE == writeregM))      forwardAE = 2'b10;
            else if ((rsE != '0) && regwriteW && (rsE == writeregW)) forwardAE = 2'b01;

            if ((rtE != '0) && regwriteM && (rtE == writeregM))      forwardBE = 2'b10;
            else if ((rtE != '0) && regwriteW && (rtE == writeregW)) forwardBE = 2'b01;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallcnt <= '0;
        end else if (stallF && (stallcnt != 16'hFFFF)) begin
            stallcnt <= stallcnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc (MUL_LAT=4): driver queues expected outputs, negedge monitor compares.
module tb_hazard_unit_mc;

    localparam int unsigned REGW = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      branchD;
    logic [3:0]      wbsrcE, wbsrcM;
    logic            regwriteE, regwriteM, regwriteW;
    logic            memopM, hitM, multstartE;
    logic [REGW-1:0] rsD, rtD, rsE, rtE;
    logic [REGW-1:0] writeregE, writeregM, writeregW;
    logic            stallF, stallD, stallE, stallM;
    logic            flushE, flushM, flushW;
    logic            forwardAD, forwardBD;
    logic [1:0]      forwardAE, forwardBE;
    logic            mulbusy;
`ifdef HAZARD_STATS_EN
    logic [15:0]     stallcnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic [13:0] exp;
    } exp_t;

    exp_t q[$];

    localparam logic [3:0] S0    = 4'b0000;
    localparam logic [3:0] S_FD  = 4'b1100;
    localparam logic [3:0] S_FDE = 4'b1110;
    localparam logic [3:0] S_ALL = 4'b1111;
    localparam logic [2:0] F0    = 3'b000;
    localparam logic [2:0] F_E   = 3'b100;
    localparam logic [2:0] F_M   = 3'b010;
    localparam logic [2:0] F_W   = 3'b001;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REGW(REGW), .MUL_LAT(4), .LOAD_WBSRC(4'b1111)) dut (
        .clk(clk), .reset_n(reset_n), .branchD(branchD),
        .wbsrcE(wbsrcE), .wbsrcM(wbsrcM),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memopM(memopM), .hitM(hitM), .multstartE(multstartE),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mulbusy(mulbusy)
`ifdef HAZARD_STATS_EN
        , .stallcnt(stallcnt)
`endif
    );

    // Expected vector: {stallF,D,E,M, flushE,M,W, fwdAD,BD, fwdAE, fwdBE, mulbusy}
    function automatic logic [13:0] mk(input logic [3:0] st, input logic [2:0] fl,
                                       input logic [1:0] fd, input logic [1:0] fae,
                                       input logic [1:0] fbe, input logic mb);
        return {st, fl, fd, fae, fbe, mb};
    endfunction

    task automatic clr();
        branchD = 2'b00; wbsrcE = 4'h0; wbsrcM = 4'h0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memopM = 1'b0; hitM = 1'b1; multstartE = 1'b0;
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
    endtask

    // Queue the expectation for the current inputs, then advance one cycle.
    task automatic cyc(input string nm, input logic [13:0] e);
        exp_t x;
        x.nm  = nm;
        x.exp = e;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [13:0] act;
            e   = q.pop_front();
            act = {stallF, stallD, stallE, stallM, flushE, flushM, flushW,
                   forwardAD, forwardBD, forwardAE, forwardBE, mulbusy};
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %b expected %b", e.nm, act, e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        clr();
        @(posedge clk);
        #1;

        // Reset: outputs low even with hazard-producing inputs present
        cyc("reset_idle", '0);
        regwriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8; multstartE = 1'b1;
        cyc("reset_masked", '0);
        clr();
        reset_n = 1'b1;
        cyc("post_reset", '0);

        // Forwarding priority
        regwriteM = 1'b1; writeregM = 5'd8; regwriteW = 1'b1; writeregW = 5'd8; rsE = 5'd8;
        cyc("fwd_M", mk(S0, F0, 2'b00, 2'b10, 2'b00, 1'b0));
        regwriteM = 1'b0;
        cyc("fwd_W", mk(S0, F0, 2'b00, 2'b01, 2'b00, 1'b0));
        rsE = '0;
        cyc("fwd_r0", '0);
        regwriteM = 1'b1; rtE = 5'd8; rsD = 5'd8;
        cyc("fwd_BE_AD", mk(S0, F0, 2'b10, 2'b00, 2'b10, 1'b0));
        clr();

        // Load-use
        wbsrcE = 4'hF; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
        cyc("lu_hit", mk(S_FD, F_E, 2'b00, 2'b00, 2'b00, 1'b0));
        writeregE = '0;
        cyc("lu_r0", '0);
        writeregE = 5'd9; wbsrcE = 4'h0;
        cyc("lu_nonload", '0);
        clr();

        // Branch interlocks
        branchD = 2'b01; regwriteE = 1'b1; writeregE = 5'd4; rsD = 5'd4;
        cyc("br_E", mk(S_FD, F_E, 2'b00, 2'b00, 2'b00, 1'b0));
        regwriteE = 1'b0; writeregE = '0; rsD = '0;
        wbsrcM = 4'hF; writeregM = 5'd4; rtD = 5'd4;
        cyc("br_Mload", mk(S_FD, F_E, 2'b00, 2'b00, 2'b00, 1'b0));
        branchD = 2'b00;
        cyc("br_none", '0);
        clr();

        // Multiply, 4 stall cycles then one busy cycle with no stall
        multstartE = 1'b1;
        cyc("mul_c1", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b0));
        cyc("mul_c2", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("mul_c3", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("mul_c4", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("mul_c5", mk(S0, F0, 2'b00, 2'b00, 2'b00, 1'b1));
        multstartE = 1'b0;
        cyc("mul_idle", '0);

        // Miss during multiply: miss from mul cycle 2 for 6 cycles
        multstartE = 1'b1;
        cyc("mms_c1", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b0));
        memopM = 1'b1; hitM = 1'b0;
        cyc("mms_c2", mk(S_ALL, F_W, 2'b00, 2'b00, 2'b00, 1'b1));
        wbsrcE = 4'hF; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
        cyc("mms_c3_lu", mk(S_ALL, F_W, 2'b00, 2'b00, 2'b00, 1'b1));
        wbsrcE = 4'h0; regwriteE = 1'b0; writeregE = '0; rtD = '0;
        cyc("mms_c4", mk(S_ALL, F_W, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("mms_c5", mk(S_ALL, F_W, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("mms_c6", mk(S_ALL, F_W, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("mms_c7", mk(S_ALL, F_W, 2'b00, 2'b00, 2'b00, 1'b1));
        hitM = 1'b1; multstartE = 1'b0;
        cyc("mms_hit", mk(S0, F0, 2'b00, 2'b00, 2'b00, 1'b1));
        clr();
        cyc("mms_idle", '0);

        // Asynchronous reset mid-multiply, then a clean restart
        multstartE = 1'b1;
        cyc("rm_c1", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b0));
        cyc("rm_c2", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b1));
        reset_n = 1'b0;
        cyc("rm_reset", '0);
        reset_n = 1'b1; multstartE = 1'b0;
        cyc("rm_idle", '0);
        multstartE = 1'b1;
        cyc("rs_c1", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b0));
        multstartE = 1'b0;
        cyc("rs_c2", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("rs_c3", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("rs_c4", mk(S_FDE, F_M, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("rs_c5", mk(S0, F0, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("rs_idle", '0);

`ifdef HAZARD_STATS_EN
        reset_n = 1'b0;
        #1;
        checks++;
        if (stallcnt !== 16'h0000) begin
            failures++;
            $display("FAIL stallcnt_reset: got %h expected 0000", stallcnt);
        end
        reset_n = 1'b1;
        memopM = 1'b1; hitM = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stallcnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stallcnt_sat: got %h expected FFFF", stallcnt);
        end
        clr();
`endif

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
